// File: rtl/mac_addr_filter_pkg.sv
// Shared constants and types for the multi-entry Ethernet destination-address filter.
// The result-type codes are what the RX framer sees on match_type.
package mac_addr_filter_pkg;

    localparam logic [1:0] MT_UNICAST = 2'd0;
    localparam logic [1:0] MT_BCAST   = 2'd1;
    localparam logic [1:0] MT_MCAST   = 2'd2;
    localparam logic [1:0] MT_PROMISC = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        HIT  = 2'd2,
        MISS = 2'd3
    } state_t;

    // match_idx is at least one bit wide even for a single-entry table.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_addr_filter_if.sv
// Framer-side handshake of the address filter: go/data toward the filter,
// the done strobe and its classification back toward the framer.
interface mac_addr_filter_if #(
    parameter int NUM_ADDR = 4
);
    import mac_addr_filter_pkg::*;

    localparam int IDX_W = idx_width(NUM_ADDR);

    logic             go;
    logic [7:0]       data;
    logic             match;
    logic [1:0]       match_type;
    logic [IDX_W-1:0] match_idx;
    logic             done;

    modport master (
        output go, data,
        input  match, match_type, match_idx, done
    );

    modport slave (
        input  go, data,
        output match, match_type, match_idx, done
    );

endinterface

// File: rtl/mac_addr_filter_entry_cmp.sv
// One unicast table entry: picks the entry byte addressed by the shared byte
// counter and keeps a sticky "still matching" candidate bit for the current DA.
module mac_addr_filter_entry_cmp
    import mac_addr_filter_pkg::*;
#(
    parameter int ADDR_BYTES = 6,
    parameter int CNT_W      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic                    step,
    input  logic [CNT_W-1:0]        cnt,
    input  logic [7:0]              data,
    input  logic [ADDR_BYTES*8-1:0] entry,
    input  logic                    valid,
    output logic                    cand_next
);

    logic       cand;
    logic [7:0] byte0;
    logic [7:0] byte_k;

    assign byte0 = entry[ADDR_BYTES*8-1 -: 8];

    always_comb begin
        byte_k = byte0;
        for (int k = 1; k < ADDR_BYTES; k++) begin
            if (cnt == CNT_W'(k)) begin
                byte_k = entry[(ADDR_BYTES-1-k)*8 +: 8];
            end
        end
    end

    // The next value is exported so the top can decide on the same edge the byte is compared.
    always_comb begin
        cand_next = cand;
        if (go) begin
            cand_next = valid & (data == byte0);
        end else if (step) begin
            cand_next = cand & valid & (data == byte_k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand <= 1'b0;
        end else begin
            cand <= cand_next;
        end
    end

endmodule

// File: rtl/mac_addr_filter.sv
// Byte-serial destination-address filter: NUM_ADDR parallel unicast entries plus
// broadcast, multicast and promiscuous acceptance, with a one-cycle done strobe.
module mac_addr_filter
    import mac_addr_filter_pkg::*;
#(
    parameter int NUM_ADDR   = 4,
    parameter int ADDR_BYTES = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    mac_addr_filter_if.slave                 bus,
    input  logic [NUM_ADDR*ADDR_BYTES*8-1:0] addr_table,
    input  logic [NUM_ADDR-1:0]              addr_valid,
    input  logic                             promisc,
    input  logic                             pass_bcast,
    input  logic                             pass_mcast
);

    localparam int CNT_W = $clog2(ADDR_BYTES + 1);
    localparam int IDX_W = idx_width(NUM_ADDR);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             bcast;
    logic             mcast;
    logic             promisc_q;
    logic             pass_bcast_q;
    logic             pass_mcast_q;
    logic             done_q;
    logic             match_q;
    logic [1:0]       type_q;
    logic [IDX_W-1:0] idx_q;

    logic                step;
    logic [NUM_ADDR-1:0] cand_next;
    logic                byte_ff;
    logic                bcast_next;
    logic                mcast_next;
    logic                eff_promisc;
    logic                eff_bcast;
    logic                eff_mcast;
    logic                accept;
    logic                last_byte;
    logic [1:0]          hit_type;
    logic [IDX_W-1:0]    hit_idx;

    assign step = (state == CMP) && !bus.go;

    for (genvar i = 0; i < NUM_ADDR; i++) begin : g_entry
        mac_addr_filter_entry_cmp #(
            .ADDR_BYTES (ADDR_BYTES),
            .CNT_W      (CNT_W)
        ) u_entry (
            .clk       (clk),
            .reset     (reset),
            .go        (bus.go),
            .step      (step),
            .cnt       (cnt),
            .data      (bus.data),
            .entry     (addr_table[i*ADDR_BYTES*8 +: ADDR_BYTES*8]),
            .valid     (addr_valid[i]),
            .cand_next (cand_next[i])
        );
    end

    // On the go cycle the mode flags come straight from the ports; later bytes use the latched copy.
    assign byte_ff     = (bus.data == 8'hFF);
    assign bcast_next  = bus.go ? byte_ff : (bcast & byte_ff);
    assign mcast_next  = bus.go ? bus.data[0] : mcast;
    assign eff_promisc = bus.go ? promisc : promisc_q;
    assign eff_bcast   = bus.go ? pass_bcast : pass_bcast_q;
    assign eff_mcast   = bus.go ? pass_mcast : pass_mcast_q;
    assign accept      = (|cand_next) | (bcast_next & eff_bcast) |
                         (mcast_next & eff_mcast) | eff_promisc;
    assign last_byte   = !bus.go && (cnt == CNT_W'(ADDR_BYTES - 1));

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_ADDR - 1; i >= 0; i--) begin
            if (cand_next[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        hit_type = MT_PROMISC;
        if (|cand_next) begin
            hit_type = MT_UNICAST;
        end else if (bcast_next & eff_bcast) begin
            hit_type = MT_BCAST;
        end else if (mcast_next & eff_mcast) begin
            hit_type = MT_MCAST;
        end
    end

    // go restarts the compare from any state; done/match are only ever set on entry to HIT/MISS.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bcast        <= 1'b0;
            mcast        <= 1'b0;
            promisc_q    <= 1'b0;
            pass_bcast_q <= 1'b0;
            pass_mcast_q <= 1'b0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            type_q       <= MT_UNICAST;
            idx_q        <= '0;
        end else begin
            done_q  <= 1'b0;
            match_q <= 1'b0;
            type_q  <= MT_UNICAST;
            idx_q   <= '0;
            if (bus.go) begin
                promisc_q    <= promisc;
                pass_bcast_q <= pass_bcast;
                pass_mcast_q <= pass_mcast;
                bcast        <= bcast_next;
                mcast        <= bus.data[0];
                cnt          <= CNT_W'(1);
                if (!accept) begin
                    state  <= MISS;
                    done_q <= 1'b1;
                end else begin
                    state <= CMP;
                end
            end else begin
                case (state)
                    CMP: begin
                        bcast <= bcast_next;
                        cnt   <= cnt + 1'b1;
                        if (!accept) begin
                            state  <= MISS;
                            done_q <= 1'b1;
                        end else if (last_byte) begin
                            state   <= HIT;
                            done_q  <= 1'b1;
                            match_q <= 1'b1;
                            type_q  <= hit_type;
                            idx_q   <= hit_idx;
                        end
                    end
                    HIT, MISS: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.done       = done_q;
    assign bus.match      = match_q;
    assign bus.match_type = type_q;
    assign bus.match_idx  = idx_q;

endmodule
